pmc_bus_initiator: RTL

PMC_BUS_INITIATOR -- requirements
Module: pmc_bus_initiator

---
 rtl/pmc_bus_initiator.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/pmc_bus_initiator.sv
// Command-queue bus initiator: buffers commands in a FIFO and runs them one at a
// time on a req/gnt/rvalid data bus, returning responses in command order.
package pmc_bus_initiator_pkg;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } cmd_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_RESP = 2'd3
    } state_e;

endpackage

module pmc_bus_initiator
    import pmc_bus_initiator_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned TIMEOUT    = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_we,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy,
    output logic        req,
    input  logic        gnt,
    output logic        we,
    output logic [3:0]  be,
    output logic [31:0] addr,
    output logic [31:0] wdata,
    input  logic        rvalid,
    input  logic [31:0] rdata,
    input  logic        err
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

    state_e             state_q, state_d;
    cmd_t               fifo_q [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]   count_q, count_d;
    cmd_t               txn_q, txn_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic               req_q, req_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [31:0]        rsp_rdata_q, rsp_rdata_d;
    logic               rsp_err_q, rsp_err_d;
    logic               push, pop, fifo_nempty, tmo_hit;
    cmd_t               cmd_in;

    assign cmd_in      = '{we: cmd_we, addr: cmd_addr, wdata: cmd_wdata};
    assign cmd_ready   = (count_q < CNT_W'(FIFO_DEPTH));
    assign push        = cmd_valid & cmd_ready;
    assign fifo_nempty = (count_q != '0);
    assign tmo_hit     = (tmo_q == TMO_W'(TIMEOUT - 1));
    assign count_d     = count_q + CNT_W'(push) - CNT_W'(pop);

    assign busy      = fifo_nempty | (state_q != S_IDLE);
    assign req       = req_q;
    assign we        = txn_q.we;
    assign be        = 4'b1111;
    assign addr      = txn_q.addr;
    assign wdata     = txn_q.wdata;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state: one bus transaction at a time, gnt/rvalid win over timeout
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (fifo_nempty) state_d = S_REQ;
            S_REQ: begin
                if (gnt)          state_d = S_WAIT;
                else if (tmo_hit) state_d = S_RESP;
            end
            S_WAIT: begin
                if (rvalid)       state_d = S_RESP;
                else if (tmo_hit) state_d = S_RESP;
            end
            S_RESP: if (rsp_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs and datapath next values; req/rsp_valid are registered from state_d
    always_comb begin
        pop         = 1'b0;
        txn_d       = txn_q;
        tmo_d       = tmo_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            S_IDLE: begin
                if (fifo_nempty) begin
                    pop   = 1'b1;
                    txn_d = fifo_q[rd_ptr_q];
                    tmo_d = '0;
                end
            end
            S_REQ: begin
                if (gnt) begin
                    tmo_d = '0;
                end else if (tmo_hit) begin
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b1;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            S_WAIT: begin
                if (rvalid) begin
                    rsp_rdata_d = (txn_q.we || err) ? '0 : rdata;
                    rsp_err_d   = err;
                end else if (tmo_hit) begin
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b1;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            default: ;
        endcase
        req_d       = (state_d == S_REQ);
        rsp_valid_d = (state_d == S_RESP);
    end

    // Control and response registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            txn_q       <= '0;
            tmo_q       <= '0;
            req_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q     <= count_d;
            txn_q       <= txn_d;
            tmo_q       <= tmo_d;
            req_q       <= req_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // FIFO storage; contents are don't-care while the count says empty
    always_ff @(posedge clk) begin
        if (push) fifo_q[wr_ptr_q] <= cmd_in;
    end

endmodule
